// File: rtl/cop_handshake.sv
// Pipeline-follower coprocessor: shadows the core's decode/execute stages, answers the
// CHSD/CHSE handshakes and owns an 8-entry register file for MCR/MRC/CDP/LDC/STC.
module cop_handshake #(
    parameter logic [3:0] CP_NUM      = 4'd7,
    parameter int         BUSY_CYCLES = 3
) (
    input  logic        nGCLK,
    input  logic        RESET,
    input  logic        nWAIT,
    input  logic [31:0] inst_if,
    input  logic        id_enbar,
    input  logic        ex_enbar,
    input  logic        cop_id,
    input  logic        cancel_ex,
    input  logic [31:0] cp_wdata,
    output logic [1:0]  CHSD,
    output logic [1:0]  CHSE,
    output logic [31:0] cp_rdata
);
    localparam logic [1:0] HS_WAIT   = 2'b00;
    localparam logic [1:0] HS_GO     = 2'b01;
    localparam logic [1:0] HS_ABSENT = 2'b10;
    localparam logic [1:0] HS_LAST   = 2'b11;
    localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, XFER, ONE} state_t;

    logic [31:0]   id_inst;
    state_t        state;
    logic [CW-1:0] busy_cnt;
    logic          beat;
    logic [2:0]    ex_crd, ex_crn, ex_crm;
    logic          ex_load, ex_two;
    logic [31:0]   c [8];

    logic       id_cdp_rt, id_mem, id_claimed, owned_id, load_op;
    logic       final_beat, write_ok;
    logic [2:0] xfer_idx;
    logic [1:0] chse;
    logic       unused_bits;

    assign unused_bits = ^{id_inst[31:28], id_inst[23], id_inst[21], id_inst[19],
                           id_inst[15], id_inst[7:5], id_inst[3]};

    assign id_cdp_rt  = (id_inst[27:24] == 4'b1110);
    assign id_mem     = (id_inst[27:25] == 3'b110);
    assign id_claimed = id_cdp_rt | id_mem;
    assign owned_id   = cop_id & (id_inst[11:8] == CP_NUM);
    assign load_op    = !ex_enbar && owned_id && id_claimed;

    assign final_beat = (beat == ex_two);
    assign xfer_idx   = ex_crd + {2'b00, beat};

    always_comb begin
        CHSD = HS_LAST;
        if (!owned_id || !id_claimed)
            CHSD = HS_ABSENT;
        else if (id_mem && id_inst[22])
            CHSD = HS_GO;
    end

    // A cancelled execute-stage op never stalls the core.
    always_comb begin
        chse = HS_LAST;
        if (!cancel_ex) begin
            case (state)
                BUSY:    if (busy_cnt != '0) chse = HS_WAIT;
                XFER:    if (!final_beat) chse = HS_GO;
                default: chse = HS_LAST;
            endcase
        end
    end
    assign CHSE = chse;

    always_comb begin
        cp_rdata = '0;
        if (state == ONE && ex_load)
            cp_rdata = c[ex_crn];
        else if (state == XFER && !ex_load)
            cp_rdata = c[xfer_idx];
    end

    // Advancing the core while we still say WAIT/GO abandons the op without writing.
    assign write_ok = !cancel_ex && !(!ex_enbar && chse != HS_LAST);

    always_ff @(posedge nGCLK or posedge RESET) begin
        if (RESET) begin
            id_inst  <= '0;
            state    <= IDLE;
            busy_cnt <= '0;
            beat     <= 1'b0;
            ex_crd   <= '0;
            ex_crn   <= '0;
            ex_crm   <= '0;
            ex_load  <= 1'b0;
            ex_two   <= 1'b0;
            for (int i = 0; i < 8; i++) c[i] <= '0;
        end else if (nWAIT) begin
            if (!id_enbar) id_inst <= inst_if;
            if (write_ok) begin
                case (state)
                    BUSY:    if (busy_cnt == '0) c[ex_crd] <= c[ex_crn] + c[ex_crm];
                    XFER:    if (ex_load) c[xfer_idx] <= cp_wdata;
                    ONE:     if (!ex_load) c[ex_crn] <= cp_wdata;
                    default: ;
                endcase
            end
            if (load_op) begin
                ex_crd   <= id_inst[14:12];
                ex_crn   <= id_inst[18:16];
                ex_crm   <= id_inst[2:0];
                ex_load  <= id_inst[20];
                ex_two   <= id_inst[22];
                busy_cnt <= CW'(BUSY_CYCLES - 1);
                beat     <= 1'b0;
                if (id_mem)
                    state <= XFER;
                else if (id_inst[4])
                    state <= ONE;
                else
                    state <= BUSY;
            end else if (cancel_ex || !ex_enbar || chse == HS_LAST) begin
                state    <= IDLE;
                busy_cnt <= '0;
                beat     <= 1'b0;
            end else if (state == BUSY) begin
                busy_cnt <= busy_cnt - 1'b1;
            end else if (state == XFER) begin
                beat <= 1'b1;
            end
        end
    end
endmodule
